// File: rtl/axi4_mem_slave.sv
// AXI4 slave memory: FIXED/INCR/WRAP bursts, byte strobes, W/R wait states, tohost mailbox.
// Independent read and write FSMs share one array; memory contents survive reset.
module axi4_mem_slave #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          ID_W        = 1,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WR_WAIT     = 0,
  parameter int          RD_WAIT     = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0800
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [ID_W-1:0]     S_AWID,
  input  logic [ADDR_W-1:0]   S_AWADDR,
  input  logic [7:0]          S_AWLEN,
  input  logic [2:0]          S_AWSIZE,
  input  logic [1:0]          S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  input  logic [DATA_W-1:0]   S_WDATA,
  input  logic [DATA_W/8-1:0] S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [ID_W-1:0]     S_BID,
  output logic [1:0]          S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  input  logic [ID_W-1:0]     S_ARID,
  input  logic [ADDR_W-1:0]   S_ARADDR,
  input  logic [7:0]          S_ARLEN,
  input  logic [2:0]          S_ARSIZE,
  input  logic [1:0]          S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [ID_W-1:0]     S_RID,
  output logic [DATA_W-1:0]   S_RDATA,
  output logic [1:0]          S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  output logic                DONE,
  output logic [31:0]         RESULT
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OB     = $clog2(STRB_W);
  localparam int IW     = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  logic              alive;
  logic [ID_W-1:0]   w_id, r_id;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic [7:0]        w_len, w_cnt, r_len, r_cnt;
  logic [2:0]        w_size, r_size;
  logic [1:0]        w_burst, w_resp, r_burst, r_resp;
  logic [3:0]        w_wait, r_wait;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] incr, mask;
    incr = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) * incr) - ADDR_W'(1);
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + incr) & mask);
      default: next_addr = a + incr;
    endcase
  endfunction

  function automatic logic bad_wrap(input logic [1:0] burst, input logic [7:0] len);
    bad_wrap = (burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

  function automatic logic [1:0] setup_resp(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    setup_resp = (size > 3'(OB) || bad_wrap(burst, len)) ? 2'b10 : 2'b00;
  endfunction

  // An illegal WRAP length is served with INCR addressing
  function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
    eff_burst = bad_wrap(burst, len) ? 2'b01 : burst;
  endfunction

  logic aw_hs, w_hs, ar_hs, w_last, r_last, w_wait_done, r_wait_done, w_oor, r_oor, mbox_hit;
  logic [IW-1:0] w_idx, r_idx;

  assign aw_hs       = S_AWVALID && S_AWREADY;
  assign w_hs        = S_WVALID && S_WREADY;
  assign ar_hs       = S_ARVALID && S_ARREADY;
  assign w_last      = (w_cnt == w_len);
  assign r_last      = (r_cnt == r_len);
  assign w_wait_done = (w_wait == 4'(WR_WAIT));
  assign r_wait_done = (r_wait == 4'(RD_WAIT));
  assign w_oor       = (w_addr >> (IW + OB)) != '0;
  assign r_oor       = (r_addr >> (IW + OB)) != '0;
  assign w_idx       = w_addr[IW+OB-1:OB];
  assign r_idx       = r_addr[IW+OB-1:OB];
  assign mbox_hit    = w_hs && (w_addr == ADDR_W'(TOHOST_ADDR)) && (&S_WSTRB) && !DONE;

  assign S_BID   = w_id;
  assign S_BRESP = w_resp;
  assign S_RID   = r_id;
  assign S_RDATA = r_data;
  assign S_RRESP = r_resp;
  assign S_RVALID = r_valid;
  assign S_RLAST = r_valid && r_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // alive keeps both READY outputs low while reset is held and for the first cycle after it
  always_comb begin
    w_next    = w_state;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AWREADY = alive;
        if (alive && S_AWVALID) w_next = W_DATA;
      end
      W_DATA: begin
        S_WREADY = w_wait_done;
        if (w_wait_done && S_WVALID && w_last) w_next = W_RESP;
      end
      W_RESP: begin
        S_BVALID = 1'b1;
        if (S_BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next    = r_state;
    S_ARREADY = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_ARREADY = alive;
        if (alive && S_ARVALID) r_next = R_DATA;
      end
      R_DATA: if (r_valid && S_RREADY && r_last) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alive   <= 1'b0;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_resp  <= '0;
      w_cnt   <= '0;
      w_wait  <= '0;
      DONE    <= 1'b0;
      RESULT  <= '0;
    end else begin
      alive <= 1'b1;
      if (aw_hs) begin
        w_id    <= S_AWID;
        w_addr  <= S_AWADDR;
        w_len   <= S_AWLEN;
        w_size  <= S_AWSIZE;
        w_burst <= eff_burst(S_AWBURST, S_AWLEN);
        w_resp  <= setup_resp(S_AWSIZE, S_AWBURST, S_AWLEN);
        w_cnt   <= '0;
        w_wait  <= '0;
      end else if (w_hs) begin
        w_cnt  <= w_cnt + 8'd1;
        w_wait <= '0;
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        if (w_resp == 2'b00)
          w_resp <= w_oor ? 2'b11 : ((S_WLAST != w_last) ? 2'b10 : 2'b00);
      end else if (w_state == W_DATA && !w_wait_done) begin
        w_wait <= w_wait + 4'd1;
      end
      if (mbox_hit) begin
        DONE   <= 1'b1;
        RESULT <= S_WDATA[31:0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_hs && !w_oor) begin
      for (int b = 0; b < STRB_W; b++)
        if (S_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_WDATA[8*b +: 8];
    end
  end

  // Read data is registered out of the array, so RVALID trails the wait count by one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_resp  <= '0;
      r_cnt   <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= S_ARID;
      r_addr  <= S_ARADDR;
      r_len   <= S_ARLEN;
      r_size  <= S_ARSIZE;
      r_burst <= eff_burst(S_ARBURST, S_ARLEN);
      r_resp  <= setup_resp(S_ARSIZE, S_ARBURST, S_ARLEN);
      r_cnt   <= '0;
      r_wait  <= '0;
      r_valid <= 1'b0;
    end else if (r_state == R_DATA) begin
      if (r_valid) begin
        if (S_RREADY) begin
          r_valid <= 1'b0;
          r_wait  <= '0;
          r_cnt   <= r_cnt + 8'd1;
          r_addr  <= next_addr(r_addr, r_len, r_size, r_burst);
        end
      end else if (r_wait_done) begin
        r_valid <= 1'b1;
        r_data  <= r_oor ? '0 : mem[r_idx];
        if (r_resp == 2'b00 && r_oor) r_resp <= 2'b11;
      end else begin
        r_wait <= r_wait + 4'd1;
      end
    end
  end

endmodule
